// File: rtl/channel_error_injector.sv
// Channel-impairment stage between the convolutional encoder and the Viterbi decoder.
// It corrupts valid symbols in bypass, periodic, LFSR-random or burst mode, with one-cycle latency.
module channel_error_injector #(
  parameter int          PERIOD    = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode_i,
  input  logic [7:0]       thresh_i,
  input  logic [3:0]       burst_len_i,
  input  logic             valid_i,
  input  logic [1:0]       d_in,
  output logic             valid_o,
  output logic [1:0]       d_out,
  output logic [1:0]       err_mask_o,
  output logic [CNT_W-1:0] sym_count_o,
  output logic [CNT_W-1:0] err_count_o
);

  localparam int             PW         = (PERIOD > 2) ? $clog2(PERIOD) : 1;
  localparam logic [PW-1:0]  PHASE_LAST = PW'(PERIOD - 1);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t        r_state;
  logic [3:0]    r_remaining;
  logic [15:0]   r_lfsr;
  logic [PW-1:0] r_phase;

  logic [15:0] w_lfsrNext;
  logic [3:0]  w_effLen;
  logic        w_phaseZero;
  logic        w_inject;
  logic [1:0]  w_mask;

  always_comb begin
    w_lfsrNext  = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
    w_effLen    = (burst_len_i == 4'd0) ? 4'd1 : burst_len_i;
    w_phaseZero = (r_phase == '0);
    w_inject    = 1'b0;
    case (mode_i)
      2'd1:    w_inject = w_phaseZero;
      2'd2:    w_inject = (r_lfsr[7:0] < thresh_i);
      2'd3:    w_inject = (r_state == S_BURST) || w_phaseZero;
      default: w_inject = 1'b0;
    endcase
    w_mask = w_inject ? (r_lfsr[8] ? 2'b10 : 2'b01) : 2'b00;
  end

  // All per-symbol state moves only on valid symbols; idle cycles freeze everything but valid_o.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr      <= LFSR_SEED;
      r_phase     <= '0;
      r_state     <= S_IDLE;
      r_remaining <= 4'd0;
      valid_o     <= 1'b0;
      d_out       <= 2'b00;
      err_mask_o  <= 2'b00;
      sym_count_o <= '0;
      err_count_o <= '0;
    end else begin
      valid_o <= valid_i;
      if (valid_i) begin
        r_lfsr     <= w_lfsrNext;
        r_phase    <= (r_phase == PHASE_LAST) ? '0 : r_phase + PW'(1);
        d_out      <= d_in ^ w_mask;
        err_mask_o <= w_mask;
        if (sym_count_o != '1)
          sym_count_o <= sym_count_o + CNT_W'(1);
        if (w_inject && (err_count_o != '1))
          err_count_o <= err_count_o + CNT_W'(1);

        // Leaving burst mode on any valid symbol abandons a burst in progress.
        if (mode_i != 2'd3) begin
          r_state     <= S_IDLE;
          r_remaining <= 4'd0;
        end else begin
          case (r_state)
            S_IDLE: begin
              if (w_phaseZero && (w_effLen > 4'd1)) begin
                r_state     <= S_BURST;
                r_remaining <= w_effLen - 4'd1;
              end
            end
            S_BURST: begin
              r_remaining <= r_remaining - 4'd1;
              if (r_remaining == 4'd1)
                r_state <= S_IDLE;
            end
            default: begin
              r_state     <= S_IDLE;
              r_remaining <= 4'd0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: doc/channel_error_injector.md
# channel_error_injector

Configurable channel-impairment stage that sits between the rate-1/2 convolutional encoder and the Viterbi decoder. It takes each valid 2-bit encoder symbol and corrupts it deterministically in one of four modes: bypass, periodic, LFSR-random or burst. It then forwards the symbol to the decoder with a registered one-cycle latency. It also keeps saturating symbol and error counters so the bench can measure the decoder's correction capability against a known injected error count.

## Interface
- PERIOD, 8 — symbols between periodic/burst trigger points; legal range 2..256.
- LFSR_SEED, 16'hACE1 — LFSR reset value; must be nonzero.
- CNT_W, 16 — width of all statistics counters.
- clk  in  1  — sole clock, rising edge.
- rst  in  1  — reset, synchronous and active-high.
- mode_i  in  2  — 0 bypass, 1 periodic, 2 random, 3 burst.
- thresh_i  in  8  — random mode: a symbol is corrupted when lfsr[7:0] < thresh_i.
- burst_len_i  in  4  — burst mode: symbols per burst; 0 is treated as 1.
- valid_i  in  1  — d_in carries a symbol this cycle.
- d_in  in  2  — encoder symbol {g1,g0}.
- valid_o  out  1  — d_out carries a symbol (valid_i delayed 1 cycle).
- d_out  out  2  — d_in XOR err_mask.
- err_mask_o  out  2  — mask applied to the symbol currently on d_out.
- sym_count_o  out  CNT_W  — valid symbols seen since reset.
- err_count_o  out  CNT_W  — symbols corrupted since reset.

## Operation
- Per-symbol state is a 16-bit Galois LFSR, a phase counter and a burst FSM.
  - LFSR polynomial x^16+x^14+x^13+x^11+1, right shift, XOR mask 16'hB400.
  - Phase counter runs 0..PERIOD-1.
  - Burst FSM has states IDLE and BURST, with a 4-bit remaining counter.
- LFSR and phase advance only on cycles where valid_i=1, in every mode including bypass.
- Phase wraps from PERIOD-1 to 0.
- Every injection flips exactly one bit.
  - The flipped bit is lfsr[8]: 0 selects bit 0 (mask 2'b01), 1 selects bit 1 (mask 2'b10).
- Injection decisions use the current (pre-advance) LFSR and phase values.
- Mode 0, bypass: mask is always 2'b00.
- Mode 1, periodic: inject when phase==0. The first valid symbol after reset is corrupted.
- Mode 2, random: inject when lfsr[7:0] < thresh_i. thresh_i=0 never injects; 255 gives a 255/256 rate.
- Mode 3, burst:
  - IDLE: at phase==0, inject. If the effective length L>1, go to BURST with remaining=L-1.
  - BURST: inject on every valid symbol and decrement remaining. Return to IDLE after injecting the symbol where remaining==1.
  - phase==0 during BURST does not retrigger.
  - burst_len_i is sampled only at the trigger.
- Mode changes take effect on the next valid symbol.
  - If mode_i≠3 on any valid symbol, the FSM forces IDLE and remaining clears.
- Counters:
  - sym_count increments on every valid symbol.
  - err_count increments on every injected symbol.
  - Both saturate at all-ones and never wrap.

## Timing
- Latency is exactly 1 cycle: a symbol at cycle t appears on d_out and valid_o at t+1, together with its err_mask_o.
- Counters update at the same edge as d_out and already include that symbol.
- Throughput is one symbol per clock. Back-to-back valids are supported, and idle gaps are supported.
- When valid_i=0:
  - valid_o=0 on the next cycle.
  - d_out and err_mask_o hold their previous values.
  - No internal state advances.
- Reset:
  - All outputs go to 0 on the first edge with rst=1.
  - lfsr=LFSR_SEED, phase=0, FSM=IDLE, remaining=0.
  - A valid_i asserted while rst=1 is dropped.
  - Reset mid-burst terminates the burst immediately.
- Simultaneous events:
  - A burst trigger coinciding with a mode change into burst uses the new mode.
  - Counter saturation coinciding with an injection still corrupts the symbol; only the count is held.

## Test plan
- Bypass: mode 0, 100 random symbols → d_out equals d_in delayed 1 cycle, err_count=0, sym_count=100.
- Periodic: PERIOD=8, mode 1, 64 consecutive valid 2'b00 symbols → exactly symbols 0,8,…,56 are nonzero.
  - Each corrupted symbol is 2'b01 or 2'b10, matching a reference-model LFSR bit 8.
  - err_count=8.
- Random: thresh 0 for 1000 symbols → err_count=0. Then thresh 128 for 4096 symbols → count matches the reference-model LFSR exactly (≈2048).
- Burst: PERIOD=8, burst_len 3, 32 symbols → symbols 0–2, 8–10, 16–18 and 24–26 corrupted, err_count=12.
  - burst_len 0 behaves as length 1.
  - burst_len 12 with PERIOD 8 produces no retrigger inside the burst.
- Gaps and reset:
  - valid_i toggling 1010… → valid_o mirrors it 1 cycle later and the phase counts only valids.
  - rst pulsed for 1 cycle mid-burst → all outputs 0, the next valid is corrupted as a new phase-0 trigger, and the LFSR restarts at 16'hACE1.
- Saturation: CNT_W=4, mode 2, thresh 255, 40 symbols → sym_count and err_count stick at 15 while corruption continues.
